// File: rtl/scroll_pkg.sv
// Shared state encoding and default geometry for the scrolling display stage.
package scroll_pkg;

  localparam int unsigned MSG_LEN_DEF = 16;
  localparam int unsigned DIGITS_DEF  = 8;
  localparam int unsigned OFS_W       = $clog2(MSG_LEN_DEF);
  localparam int unsigned IDX_W       = $clog2(DIGITS_DEF);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSE   = 2'd1,
    ST_RESTART = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a registered rising-edge strobe on the synced level.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_rise;

endmodule

// File: rtl/scroll_engine.sv
// Scrolls a hex message ring across a multiplexed 7-segment display.
// Optional SCROLL_BLINK_EN: blanks the display on a half-step cadence while paused.
module scroll_engine
  import scroll_pkg::*;
#(
  parameter int unsigned MSG_LEN  = MSG_LEN_DEF,
  parameter int unsigned DIGITS   = DIGITS_DEF,
  parameter int unsigned STEP_DIV = 50_000_000,
  parameter int unsigned SCAN_DIV = 12_500
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       restart_in,
  input  logic                       pause_in,
  input  logic [MSG_LEN*4-1:0]       msg,
  output logic [DIGITS-1:0]          an_n,
  output logic [3:0]                 digit_code,
  output logic [$clog2(MSG_LEN)-1:0] offset,
  output logic                       paused,
  output logic                       step_pulse
);

  localparam int unsigned OFFSET_W = $clog2(MSG_LEN);
  localparam int unsigned SUM_W    = OFFSET_W + 1;
  localparam int unsigned SIDX_W   = $clog2(DIGITS);
  localparam int unsigned PRE_W    = $clog2(STEP_DIV);
  localparam int unsigned SCNT_W   = $clog2(SCAN_DIV);

  // (a + b) mod MSG_LEN with one conditional subtract; both operands < MSG_LEN
  function automatic logic [OFFSET_W-1:0] mod_add(input logic [OFFSET_W-1:0] a,
                                                  input logic [SUM_W-1:0]    b);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + b;
    if (s >= SUM_W'(MSG_LEN)) s = s - SUM_W'(MSG_LEN);
    return s[OFFSET_W-1:0];
  endfunction

  logic w_restart_ev;
  logic w_pause_s;
  logic w_unused_pause_rise;

  sync_edge u_sync_restart (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (restart_in),
    .o_level (),
    .o_rise  (w_restart_ev)
  );

  sync_edge u_sync_pause (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (pause_in),
    .o_level (w_pause_s),
    .o_rise  (w_unused_pause_rise)
  );

  state_e                r_state, w_next_state;
  logic [PRE_W-1:0]      r_presc, w_presc_nxt;
  logic [OFFSET_W-1:0]   r_offset, w_offset_nxt;
  logic                  r_step_pulse, w_step_nxt;
  logic                  r_paused;
  logic [SCNT_W-1:0]     r_scan_cnt;
  logic [SIDX_W-1:0]     r_scan_idx;
  logic [DIGITS-1:0]     r_an_scan, w_an_scan_nxt;
  logic [3:0]            r_digit_code, w_digit_nxt;
  logic                  w_slot;
  logic [OFFSET_W-1:0]   w_char_idx;
  logic [3:0]            w_chars [MSG_LEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_next_state;
  end

  // Restart beats pause changes; RESTART always lasts a single cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:     if (w_restart_ev) w_next_state = ST_RESTART;
                  else if (w_pause_s) w_next_state = ST_PAUSE;
      ST_PAUSE:   if (w_restart_ev) w_next_state = ST_RESTART;
                  else if (!w_pause_s) w_next_state = ST_RUN;
      ST_RESTART: w_next_state = w_pause_s ? ST_PAUSE : ST_RUN;
      default:    w_next_state = ST_RUN;
    endcase
  end

  // Offset/prescaler updates; a restart event discards a coincident terminal count
  always_comb begin
    w_presc_nxt  = r_presc;
    w_offset_nxt = r_offset;
    w_step_nxt   = 1'b0;
    if (w_next_state == ST_RESTART) begin
      w_presc_nxt  = '0;
      w_offset_nxt = '0;
    end else if (!w_pause_s) begin
      if (r_state == ST_RUN) begin
        if (r_presc == PRE_W'(STEP_DIV - 1)) begin
          w_presc_nxt  = '0;
          w_offset_nxt = mod_add(r_offset, SUM_W'(1));
          w_step_nxt   = 1'b1;
        end else begin
          w_presc_nxt = r_presc + PRE_W'(1);
        end
      end else if (r_state == ST_RESTART) begin
        w_presc_nxt = r_presc + PRE_W'(1);
      end
    end
  end

  always_comb begin
    for (int j = 0; j < MSG_LEN; j++) w_chars[j] = msg[4*j +: 4];
  end

  always_comb begin
    w_slot        = (r_scan_cnt == SCNT_W'(SCAN_DIV - 1));
    w_char_idx    = mod_add(r_offset, SUM_W'(r_scan_idx));
    w_an_scan_nxt = r_an_scan;
    w_digit_nxt   = r_digit_code;
    if (w_slot) begin
      w_an_scan_nxt = ~(DIGITS'(1) << r_scan_idx);
      w_digit_nxt   = w_chars[w_char_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_offset     <= '0;
      r_step_pulse <= 1'b0;
      r_paused     <= 1'b0;
      r_scan_cnt   <= '0;
      r_scan_idx   <= '0;
      r_an_scan    <= '1;
      r_digit_code <= '0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_offset     <= w_offset_nxt;
      r_step_pulse <= w_step_nxt;
      r_paused     <= (w_next_state == ST_PAUSE);
      r_an_scan    <= w_an_scan_nxt;
      r_digit_code <= w_digit_nxt;
      if (w_slot) begin
        r_scan_cnt <= '0;
        r_scan_idx <= (r_scan_idx == SIDX_W'(DIGITS - 1)) ? '0 : r_scan_idx + SIDX_W'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + SCNT_W'(1);
      end
    end
  end

`ifdef SCROLL_BLINK_EN
  logic [PRE_W-1:0]  r_blink_cnt, w_blink_cnt_nxt;
  logic              r_blink, w_blink_nxt;
  logic [DIGITS-1:0] r_an_n;

  // Blink phase restarts blanked on every PAUSE entry
  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_nxt     = r_blink;
    if (w_next_state == ST_PAUSE) begin
      if (r_state != ST_PAUSE) begin
        w_blink_cnt_nxt = '0;
        w_blink_nxt     = 1'b0;
      end else if (r_blink_cnt == PRE_W'(STEP_DIV/2 - 1)) begin
        w_blink_cnt_nxt = '0;
        w_blink_nxt     = ~r_blink;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_an_n      <= '1;
    end else begin
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink     <= w_blink_nxt;
      r_an_n      <= ((w_next_state == ST_PAUSE) && !w_blink_nxt) ? '1 : w_an_scan_nxt;
    end
  end

  assign an_n = r_an_n;
`else
  assign an_n = r_an_scan;
`endif

  assign digit_code = r_digit_code;
  assign offset     = r_offset;
  assign paused     = r_paused;
  assign step_pulse = r_step_pulse;

endmodule

// File: doc/scroll_engine.md
Name: scroll_engine

Overview:
Scrolling-display stage directly downstream of the button/switch debouncer. It consumes the debounced reset pulse (S0) and pause level (SW7). It advances a scroll offset through a hex message at a fixed step rate and time-multiplexes the visible window onto an 8-digit 7-segment display as a scan-enable plus a 4-bit digit code. It feeds the hex-to-segment decoder.

Parameters:
MSG_LEN, 16, number of 4-bit characters in the message ring (2..64)
DIGITS, 8, number of physical display digits (<= MSG_LEN)
STEP_DIV, 50_000_000, clk cycles per scroll step (2 Hz at 100 MHz)
SCAN_DIV, 12_500, clk cycles per digit scan slot (1 kHz full refresh at 8 digits)

Ports:
clk  in  1  100 MHz system clock
rst_n  in  1  asynchronous active-low reset
restart_in  in  1  debounced S0; pulse about 10 ms wide, generated in the debouncer's slow domain
pause_in  in  1  debounced SW7 level; 1 = pause scrolling
msg  in  MSG_LEN*4  message ring; char j = msg[4j+3:4j]; static during operation
an_n  out  DIGITS  active-low digit enables; exactly one low after the first scan slot
digit_code  out  4  character shown on the currently enabled digit
offset  out  clog2(MSG_LEN)  current scroll offset
paused  out  1  1 while in PAUSE state
step_pulse  out  1  one-cycle strobe on each offset advance

Behaviour:
- Reset (async assert, sync release): offset=0, state=RUN, prescaler=0, scan_idx=0, an_n=all 1s, digit_code=0, paused=0, step_pulse=0, synchronizer flops=0.
- Input sync: restart_in and pause_in each pass through a 2-flop synchronizer. A restart event is the rising edge of synced restart: a 1-cycle pulse, 3 clk edges after restart_in rises. A 10 ms-wide input yields exactly one event.
- FSM states: RUN, PAUSE, RESTART.
  - RUN: prescaler counts 0..STEP_DIV-1. At terminal count, offset advances, prescaler returns to 0, and step_pulse=1 for that cycle. Go to PAUSE when synced pause=1.
  - PAUSE: prescaler frozen, not cleared. offset held. Go to RUN when synced pause=0; counting resumes from the frozen value.
  - RESTART: entered from RUN or PAUSE on a restart event. Lasts one cycle: offset←0, prescaler←0, no step_pulse. Next state is PAUSE if synced pause=1, else RUN.
- Priority: restart event > pause change > step. A step terminal count in the same cycle as a restart event is discarded.
- Wrap: offset MSG_LEN-1 advances to 0. No other bound applies.
- paused is registered: 1 in PAUSE, 0 otherwise (0 in RESTART).
- Scan:
  - The scan counter runs in every state, including pause.
  - scan_idx advances 0..DIGITS-1 and wraps, every SCAN_DIV cycles.
  - an_n and digit_code are registered together. an_n[scan_idx]=0, all other bits 1.
  - digit_code = msg char (offset+scan_idx) mod MSG_LEN, using the offset value in the cycle the slot begins.
  - Digit 0 is leftmost. The first slot is driven on the first SCAN_DIV terminal count after reset.
- Modulo arithmetic uses a clog2(MSG_LEN)+1-bit sum with conditional subtract. No divider.
- Reset mid-step or mid-scan returns all state to reset values immediately.

Optional Feature:
SCROLL_BLINK_EN:
- When defined, the display blinks while paused. A blink toggle flips every STEP_DIV/2 cycles, counted by its own counter, which runs only while in PAUSE. While the toggle is 0, an_n is forced to all 1s.
- The toggle is cleared on entry to PAUSE, so the display starts blanked.
- When not defined, the display stays steadily lit in PAUSE and the blink logic is not synthesized.

Decomposition:
- Package scroll_pkg holds:
  - state encoding: RUN=2'd0, PAUSE=2'd1, RESTART=2'd2
  - width helper constants: OFS_W=clog2(MSG_LEN), IDX_W=clog2(DIGITS)
- Sub-module sync_edge: 2-flop synchronizer with a registered rising-edge output. It is instantiated for restart_in (edge used) and pause_in (level output only).

Test Plan (STEP_DIV=4, SCAN_DIV=2, MSG_LEN=16, DIGITS=8, msg=64'hFEDCBA9876543210):
1. Release reset, run 40 cycles -> step_pulse every 4 cycles. offset goes 0,1,2,…,9. an_n cycles FE,FD,FB,…,7F. At offset=3 with scan_idx=0, digit_code=3.
2. Run past offset 15 -> next step gives offset=0. At offset=12, scan_idx=7 shows digit_code=(12+7)%16=3.
3. Assert pause_in at prescaler=2 for 20 cycles -> paused=1 after 3 cycles, offset constant, scan continues. Deassert -> first step_pulse 2 cycles after RUN resumes.
4. Hold restart_in high 50 cycles at offset=9 -> one RESTART, offset=0 on the 4th edge, no second event, next step 4 cycles later.
5. Restart while pause_in=1 -> offset=0, paused=1 throughout except 1 cycle in RESTART. Restart edge coincident with step terminal count -> offset=0, no step_pulse.
6. With SCROLL_BLINK_EN, pause 20 cycles -> an_n all 1s for 2 cycles, then scanning for 2, alternating. Without it, an_n scans continuously.
